// File: rtl/multi_cycle_ctrl.sv
// Stage sequencer for the multi-cycle core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// with fetch and load/store handshakes, halt-on-ebreak, bus watchdog and retire counter.
module multi_cycle_ctrl #(
   parameter int unsigned TIMEOUT = 256,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             ifu_req,
   input  logic             ifu_rvalid,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_ebreak,
   output logic             lsu_req,
   output logic             lsu_wen,
   input  logic             lsu_rvalid,
   output logic             commit,
   output logic             pc_wen,
   output logic [2:0]       state_o,
   output logic             halted,
   output logic             timeout_err,
   output logic [CNT_W-1:0] retired_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_HALT      = 3'd6
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [15:0]      wait_cnt_r;
   logic             wait_last_s;
   logic             timeout_hit_s;
   logic             timeout_err_r;
   logic [CNT_W-1:0] retired_cnt_r;

   // Next-state decode; a response on the last allowed wait cycle beats the watchdog
   always_comb begin
      state_nxt_s   = state_r;
      timeout_hit_s = 1'b0;
      wait_last_s   = (wait_cnt_r == WAIT_LAST);
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_FETCH;
         end
         ST_FETCH: begin
            if (ifu_rvalid) begin
               state_nxt_s = ST_DECODE;
            end else if (wait_last_s) begin
               state_nxt_s   = ST_HALT;
               timeout_hit_s = 1'b1;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (is_ebreak) begin
               state_nxt_s = ST_HALT;
            end else begin
               state_nxt_s = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            if (is_load || is_store) begin
               state_nxt_s = ST_MEMORY;
            end else begin
               state_nxt_s = ST_WRITEBACK;
            end
         end
         ST_MEMORY: begin
            if (lsu_rvalid) begin
               state_nxt_s = ST_WRITEBACK;
            end else if (wait_last_s) begin
               state_nxt_s   = ST_HALT;
               timeout_hit_s = 1'b1;
            end else begin
               state_nxt_s = ST_MEMORY;
            end
         end
         ST_WRITEBACK: begin
            state_nxt_s = ST_FETCH;
         end
         ST_HALT: begin
            state_nxt_s = ST_HALT;
         end
         default: begin
            state_nxt_s = ST_HALT;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Wait counter: restarts on every state change, counts only while a bus wait is held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_r <= 16'd0;
      end else if (state_nxt_s != state_r) begin
         wait_cnt_r <= 16'd0;
      end else if ((state_r == ST_FETCH) || (state_r == ST_MEMORY)) begin
         wait_cnt_r <= wait_cnt_r + 16'd1;
      end else begin
         wait_cnt_r <= 16'd0;
      end
   end

   // Sticky watchdog flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_err_r <= 1'b0;
      end else if (timeout_hit_s) begin
         timeout_err_r <= 1'b1;
      end else begin
         timeout_err_r <= timeout_err_r;
      end
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_WRITEBACK) begin
         retired_cnt_r <= retired_cnt_r + CNT_W'(1);
      end else begin
         retired_cnt_r <= retired_cnt_r;
      end
   end

   // Outputs are pure decodes of state; a store wins when both load and store are flagged
   assign ifu_req     = (state_r == ST_FETCH);
   assign lsu_req     = (state_r == ST_MEMORY);
   assign lsu_wen     = (state_r == ST_MEMORY) & is_store;
   assign commit      = (state_r == ST_WRITEBACK);
   assign pc_wen      = (state_r == ST_WRITEBACK);
   assign halted      = (state_r == ST_HALT);
   assign state_o     = state_r;
   assign timeout_err = timeout_err_r;
   assign retired_cnt = retired_cnt_r;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl with TIMEOUT=4 and a 2-bit retire counter.
module tb_multi_cycle_ctrl;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ifu_req, ifu_rvalid;
   logic          is_load, is_store, is_ebreak;
   logic          lsu_req, lsu_wen, lsu_rvalid;
   logic          commit, pc_wen, halted, timeout_err;
   logic [2:0]    state_o;
   logic [CW-1:0] retired_cnt;

   int checks = 0;
   int errors = 0;
   int req_cycles;

   multi_cycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid),
      .is_load(is_load), .is_store(is_store), .is_ebreak(is_ebreak),
      .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_rvalid(lsu_rvalid),
      .commit(commit), .pc_wen(pc_wen), .state_o(state_o),
      .halted(halted), .timeout_err(timeout_err), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in the first FETCH cycle: response at once, lands in DECODE
   task automatic fetch_now();
      check("fetch_state", 32'(state_o), 32'd1);
      check("fetch_req", 32'(ifu_req), 32'd1);
      ifu_rvalid = 1'b1;
      tick();
      ifu_rvalid = 1'b0;
      check("decode_state", 32'(state_o), 32'd2);
      check("decode_nocommit", 32'(commit), 32'd0);
   endtask

   task automatic run_alu(input logic [CW-1:0] exp_ret);
      fetch_now();
      tick();
      check("alu_exec", 32'(state_o), 32'd3);
      tick();
      check("alu_wb", 32'(state_o), 32'd5);
      check("alu_commit", 32'(commit), 32'd1);
      check("alu_pcwen", 32'(pc_wen), 32'd1);
      tick();
      check("alu_refetch", 32'(state_o), 32'd1);
      check("alu_commit_off", 32'(commit), 32'd0);
      check("alu_retired", 32'(retired_cnt), 32'(exp_ret));
   endtask

   initial begin
      rst_n = 1'b0; ifu_rvalid = 1'b0; lsu_rvalid = 1'b0;
      is_load = 1'b0; is_store = 1'b0; is_ebreak = 1'b0;
      repeat (2) tick();
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_outs", {26'd0, ifu_req, lsu_req, commit, pc_wen, halted, timeout_err}, 32'd0);
      check("rst_retired", 32'(retired_cnt), 32'd0);

      rst_n = 1'b1;
      tick();
      run_alu(2'd1);

      // Load, response in the 4th MEMORY cycle (also the watchdog boundary)
      is_load = 1'b1;
      fetch_now();
      tick();
      check("ld_exec", 32'(state_o), 32'd3);
      tick();
      check("ld_mem", 32'(state_o), 32'd4);
      check("ld_wen", 32'(lsu_wen), 32'd0);
      req_cycles = lsu_req ? 1 : 0;
      repeat (3) begin
         tick();
         if (lsu_req) req_cycles++;
      end
      lsu_rvalid = 1'b1;
      tick();
      lsu_rvalid = 1'b0;
      is_load    = 1'b0;
      check("ld_req_cycles", 32'(req_cycles), 32'd4);
      check("ld_wb", 32'(state_o), 32'd5);
      check("ld_req_off", 32'(lsu_req), 32'd0);
      check("ld_noerr", 32'(timeout_err), 32'd0);
      tick();
      check("ld_retired", 32'(retired_cnt), 32'd2);

      // Load+store flagged together acts as a store
      is_load = 1'b1; is_store = 1'b1;
      fetch_now();
      tick();
      tick();
      check("st_mem", 32'(state_o), 32'd4);
      check("st_wen", 32'(lsu_wen), 32'd1);
      lsu_rvalid = 1'b1;
      #1;
      check("st_wen_ack", 32'(lsu_wen), 32'd1);
      tick();
      lsu_rvalid = 1'b0; is_load = 1'b0; is_store = 1'b0;
      check("st_wb", 32'(state_o), 32'd5);
      check("st_wen_off", 32'(lsu_wen), 32'd0);
      tick();
      check("st_retired", 32'(retired_cnt), 32'd3);

      run_alu(2'd0);
      run_alu(2'd1);

      // Fetch response on the 4th FETCH cycle still advances
      check("tob_fetch", 32'(state_o), 32'd1);
      repeat (3) begin
         tick();
         check("tob_hold", 32'(state_o), 32'd1);
      end
      ifu_rvalid = 1'b1;
      tick();
      ifu_rvalid = 1'b0;
      check("tob_decode", 32'(state_o), 32'd2);
      check("tob_noerr", 32'(timeout_err), 32'd0);

      // Ebreak in DECODE
      is_ebreak = 1'b1;
      tick();
      is_ebreak = 1'b0;
      check("eb_state", 32'(state_o), 32'd6);
      check("eb_halted", 32'(halted), 32'd1);
      check("eb_noerr", 32'(timeout_err), 32'd0);
      ifu_rvalid = 1'b1;
      repeat (3) begin
         tick();
         check("eb_absorb", 32'(state_o), 32'd6);
         check("eb_commit", 32'(commit), 32'd0);
         check("eb_ifureq", 32'(ifu_req), 32'd0);
      end
      ifu_rvalid = 1'b0;
      check("eb_retired", 32'(retired_cnt), 32'd1);

      // Reset mid-MEMORY drops the request immediately
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      is_load = 1'b1;
      fetch_now();
      tick();
      tick();
      check("mr_mem", 32'(lsu_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_req_drop", 32'(lsu_req), 32'd0);
      check("mr_state", 32'(state_o), 32'd0);
      check("mr_halted", 32'(halted), 32'd0);
      check("mr_retired", 32'(retired_cnt), 32'd0);
      tick();
      rst_n = 1'b1; is_load = 1'b0;
      tick();

      // Fetch never answered: HALT after 4 FETCH cycles with timeout_err
      check("to_fetch", 32'(state_o), 32'd1);
      repeat (3) begin
         tick();
         check("to_hold", 32'(state_o), 32'd1);
      end
      tick();
      check("to_state", 32'(state_o), 32'd6);
      check("to_err", 32'(timeout_err), 32'd1);
      check("to_halted", 32'(halted), 32'd1);
      check("to_req_off", 32'(ifu_req), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Stage sequencer for the multi-cycle core. Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and handshakes with the instruction-fetch and load/store memory ports. Generates the single-cycle commit pulse that gates register write-back, plus the PC write enable. Also provides halt-on-ebreak, a bus-timeout watchdog and a retired-instruction counter.

Parameters:
TIMEOUT, 256, max wait cycles in FETCH or MEMORY before a timeout error; legal range 2..65535
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
ifu_req  output  1  instruction fetch request; held high while in FETCH
ifu_rvalid  input  1  fetch data valid; the instruction is latched elsewhere on this cycle
is_load  input  1  decoded load; valid from DECODE through WRITEBACK
is_store  input  1  decoded store; valid from DECODE through WRITEBACK
is_ebreak  input  1  decoded instruction equals 32'h00100073; sampled in DECODE
lsu_req  output  1  data memory request; held high while in MEMORY
lsu_wen  output  1  data memory write enable; equals is_store while lsu_req is high, else 0
lsu_rvalid  input  1  data memory response or ack
commit  output  1  one-cycle pulse in WRITEBACK; drives the write-back commit input
pc_wen  output  1  one-cycle pulse in WRITEBACK; the PC register loads next-PC
state_o  output  3  current state encoding, for debug
halted  output  1  sticky; high in HALT
timeout_err  output  1  sticky; high if HALT was reached by timeout
retired_cnt  output  CNT_W  count of committed instructions

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. Codes 7 and any illegal value go to HALT with timeout_err=0.
- Reset, asynchronous on rst_n low:
  - state=IDLE; all outputs 0; retired_cnt=0; wait counter=0.
  - Takes effect immediately, even mid-handshake. Outstanding requests drop at once.
- IDLE -> FETCH on the first clock edge after rst_n goes high.
- FETCH:
  - ifu_req=1.
  - On ifu_rvalid=1 -> DECODE next cycle.
- DECODE, 1 cycle:
  - If is_ebreak=1 -> HALT. No commit, halted=1, timeout_err=0.
  - Otherwise -> EXECUTE.
- EXECUTE, 1 cycle:
  - -> MEMORY if is_load or is_store; otherwise -> WRITEBACK.
- MEMORY:
  - lsu_req=1.
  - lsu_wen=is_store. If is_load and is_store are both high, treat the access as a store.
  - On lsu_rvalid=1 -> WRITEBACK.
- WRITEBACK, 1 cycle:
  - commit=1, pc_wen=1.
  - retired_cnt increments by 1 and wraps from all-ones to 0.
  - -> FETCH.
- Minimum instruction latency:
  - 4 cycles for non-memory instructions: FETCH (with rvalid on the first cycle), DECODE, EXECUTE, WRITEBACK.
  - 5 cycles for loads and stores.
- Wait counter:
  - Cleared on entry to FETCH or MEMORY; increments each cycle the state is held without a valid response.
  - If the counter equals TIMEOUT-1 and no valid response arrives that cycle -> HALT with timeout_err=1.
  - A valid response arriving on the boundary cycle wins: advance normally, no error.
- ifu_rvalid outside FETCH and lsu_rvalid outside MEMORY are ignored and have no state effect.
- HALT:
  - Absorbing until reset.
  - All request and pulse outputs are 0; halted=1; retired_cnt is frozen.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs, except lsu_wen, which depends on is_store.

Test Plan:
- Reset, then ALU instruction: release rst_n, ifu_rvalid=1 on the first FETCH cycle, is_load=is_store=0 -> state sequence 0,1,2,3,5,1. commit and pc_wen high only in state 5. retired_cnt=1.
- Load with delayed response: lsu_rvalid arrives 3 cycles after entering MEMORY -> lsu_req high for exactly 4 cycles, lsu_wen=0, one commit pulse, retired_cnt increments by 1.
- Store with is_load=is_store=1 -> lsu_wen=1 throughout MEMORY.
- Ebreak: is_ebreak=1 in DECODE -> next state 6, halted=1, commit never pulses, retired_cnt unchanged. Further ifu_rvalid pulses have no effect.
- Timeout with TIMEOUT=4: FETCH with no ifu_rvalid -> HALT after 4 FETCH cycles with timeout_err=1. Rerun with ifu_rvalid on the 4th cycle -> DECODE, no error.
- Mid-op reset and wrap:
  - Assert rst_n low while in MEMORY -> lsu_req drops immediately, state_o=0.
  - With CNT_W=2, commit 5 instructions -> retired_cnt reads 1, 2, 3, 0, 1.
